register_bank: RTL and testbench

//   32 x 32-bit architectural register storage feeding the read multiplexer.

---
 rtl/register_bank.sv | 171 +++++++++++++++++
 tb/tb_register_bank.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/register_bank.sv
// register_bank: 32 x 32-bit architectural register storage with byte-enabled write-back.
// It has a per-register pending scoreboard (issue reserves, write-back clears), a one-cycle
// stray write-back flag, and a committed-write counter. Every output comes straight from a flop.
// Optional build macro: ZERO_REG_EN. When it is defined, R0 is hard-wired to zero and
// reservations to address 0 are ignored.
module register_bank #(
   parameter int DATA_W = 32,
   parameter int NREG   = 32,
   parameter int CNT_W  = 16
) (
   input  logic                Clock,
   input  logic                Reset_n,
   input  logic                WrEn,
   input  logic [4:0]          WrAdd,
   input  logic [DATA_W-1:0]   WrData,
   input  logic [DATA_W/8-1:0] WrByteEn,
   input  logic                ResvEn,
   input  logic [4:0]          ResvAdd,
   output logic [DATA_W-1:0]   R0,
   output logic [DATA_W-1:0]   R1,
   output logic [DATA_W-1:0]   R2,
   output logic [DATA_W-1:0]   R3,
   output logic [DATA_W-1:0]   R4,
   output logic [DATA_W-1:0]   R5,
   output logic [DATA_W-1:0]   R6,
   output logic [DATA_W-1:0]   R7,
   output logic [DATA_W-1:0]   R8,
   output logic [DATA_W-1:0]   R9,
   output logic [DATA_W-1:0]   R10,
   output logic [DATA_W-1:0]   R11,
   output logic [DATA_W-1:0]   R12,
   output logic [DATA_W-1:0]   R13,
   output logic [DATA_W-1:0]   R14,
   output logic [DATA_W-1:0]   R15,
   output logic [DATA_W-1:0]   R16,
   output logic [DATA_W-1:0]   R17,
   output logic [DATA_W-1:0]   R18,
   output logic [DATA_W-1:0]   R19,
   output logic [DATA_W-1:0]   R20,
   output logic [DATA_W-1:0]   R21,
   output logic [DATA_W-1:0]   R22,
   output logic [DATA_W-1:0]   R23,
   output logic [DATA_W-1:0]   R24,
   output logic [DATA_W-1:0]   R25,
   output logic [DATA_W-1:0]   R26,
   output logic [DATA_W-1:0]   R27,
   output logic [DATA_W-1:0]   R28,
   output logic [DATA_W-1:0]   R29,
   output logic [DATA_W-1:0]   R30,
   output logic [DATA_W-1:0]   R31,
   output logic [NREG-1:0]     Pending,
   output logic                StrayWr,
   output logic [CNT_W-1:0]    WrCount
);

   localparam int NBYTE = DATA_W / 8;

`ifdef ZERO_REG_EN
   localparam bit ZERO_REG = 1'b1;
`else
   localparam bit ZERO_REG = 1'b0;
`endif

   logic [DATA_W-1:0] regs_reg  [NREG];
   logic [DATA_W-1:0] regs_next [NREG];
   logic [NREG-1:0]   pending_reg;
   logic [NREG-1:0]   pending_next;
   logic              stray_reg;
   logic              stray_next;
   logic [CNT_W-1:0]  count_reg;
   logic [CNT_W-1:0]  count_next;
   logic              committed;
   logic [DATA_W-1:0] be_mask;
   logic [NREG-1:0]   wr_hit;
   logic [NREG-1:0]   resv_hit;

   // A write with no byte enabled is a no-op everywhere, including the counter and scoreboard.
   assign committed = WrEn && (WrByteEn != '0);

   // Expand the byte enables into a bit mask for merging.
   genvar bi;
   generate
      for (bi = 0; bi < NBYTE; bi++) begin : g_mask
         assign be_mask[8*bi +: 8] = {8{WrByteEn[bi]}};
      end
   endgenerate

   // Compute the next data word and pending bit for each register.
   // A reservation on the same edge as the write-back wins, so pending stays set.
   genvar gi;
   generate
      for (gi = 0; gi < NREG; gi++) begin : g_reg
         logic hard_zero;
         assign hard_zero        = ZERO_REG && (gi == 0);
         assign wr_hit[gi]       = committed && (WrAdd == 5'(gi));
         assign resv_hit[gi]     = ResvEn && (ResvAdd == 5'(gi)) && !hard_zero;
         assign regs_next[gi]    = (wr_hit[gi] && !hard_zero)
                                   ? ((WrData & be_mask) | (regs_reg[gi] & ~be_mask))
                                   : regs_reg[gi];
         assign pending_next[gi] = resv_hit[gi] | (pending_reg[gi] & ~wr_hit[gi]);
      end
   endgenerate

   // Stray is judged on the pending bit as it was before this edge.
   assign stray_next = committed && !pending_reg[WrAdd] && !(ZERO_REG && (WrAdd == 5'd0));
   assign count_next = committed ? (count_reg + CNT_W'(1)) : count_reg;

   // Register file storage.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs_reg[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREG; i++) begin
            regs_reg[i] <= regs_next[i];
         end
      end
   end

   // Pending scoreboard, stray flag and committed-write counter.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         pending_reg <= '0;
         stray_reg   <= 1'b0;
         count_reg   <= '0;
      end else begin
         pending_reg <= pending_next;
         stray_reg   <= stray_next;
         count_reg   <= count_next;
      end
   end

   assign Pending = pending_reg;
   assign StrayWr = stray_reg;
   assign WrCount = count_reg;

   assign R0  = regs_reg[0];
   assign R1  = regs_reg[1];
   assign R2  = regs_reg[2];
   assign R3  = regs_reg[3];
   assign R4  = regs_reg[4];
   assign R5  = regs_reg[5];
   assign R6  = regs_reg[6];
   assign R7  = regs_reg[7];
   assign R8  = regs_reg[8];
   assign R9  = regs_reg[9];
   assign R10 = regs_reg[10];
   assign R11 = regs_reg[11];
   assign R12 = regs_reg[12];
   assign R13 = regs_reg[13];
   assign R14 = regs_reg[14];
   assign R15 = regs_reg[15];
   assign R16 = regs_reg[16];
   assign R17 = regs_reg[17];
   assign R18 = regs_reg[18];
   assign R19 = regs_reg[19];
   assign R20 = regs_reg[20];
   assign R21 = regs_reg[21];
   assign R22 = regs_reg[22];
   assign R23 = regs_reg[23];
   assign R24 = regs_reg[24];
   assign R25 = regs_reg[25];
   assign R26 = regs_reg[26];
   assign R27 = regs_reg[27];
   assign R28 = regs_reg[28];
   assign R29 = regs_reg[29];
   assign R30 = regs_reg[30];
   assign R31 = regs_reg[31];

endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: table-driven checks with a scoreboard queue, plus hand sequences for
// counter wrap, the no-byte-enable write and asynchronous reset in the middle of a cycle.
module tb_register_bank;

   logic        Clock;
   logic        Reset_n;
   logic        WrEn;
   logic [4:0]  WrAdd;
   logic [31:0] WrData;
   logic [3:0]  WrByteEn;
   logic        ResvEn;
   logic [4:0]  ResvAdd;
   logic [31:0] Pending;
   logic        StrayWr;
   logic [15:0] WrCount;
   logic [31:0] r_out [32];

   int checks   = 0;
   int failures = 0;

   register_bank dut (
      .Clock(Clock), .Reset_n(Reset_n),
      .WrEn(WrEn), .WrAdd(WrAdd), .WrData(WrData), .WrByteEn(WrByteEn),
      .ResvEn(ResvEn), .ResvAdd(ResvAdd),
      .R0(r_out[0]),   .R1(r_out[1]),   .R2(r_out[2]),   .R3(r_out[3]),
      .R4(r_out[4]),   .R5(r_out[5]),   .R6(r_out[6]),   .R7(r_out[7]),
      .R8(r_out[8]),   .R9(r_out[9]),   .R10(r_out[10]), .R11(r_out[11]),
      .R12(r_out[12]), .R13(r_out[13]), .R14(r_out[14]), .R15(r_out[15]),
      .R16(r_out[16]), .R17(r_out[17]), .R18(r_out[18]), .R19(r_out[19]),
      .R20(r_out[20]), .R21(r_out[21]), .R22(r_out[22]), .R23(r_out[23]),
      .R24(r_out[24]), .R25(r_out[25]), .R26(r_out[26]), .R27(r_out[27]),
      .R28(r_out[28]), .R29(r_out[29]), .R30(r_out[30]), .R31(r_out[31]),
      .Pending(Pending), .StrayWr(StrayWr), .WrCount(WrCount)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   typedef struct {
      logic        wr_en;
      logic [4:0]  wr_add;
      logic [31:0] wr_data;
      logic [3:0]  be;
      logic        resv_en;
      logic [4:0]  resv_add;
      logic [4:0]  chk_add;
      logic [31:0] exp_data;
      logic [31:0] exp_pend;
      logic        exp_stray;
      logic [15:0] exp_cnt;
   } vec_t;

   localparam int NVEC = 16;
   vec_t vecs [NVEC];
   vec_t sb_q [$];

   function automatic vec_t mk(logic we, logic [4:0] wa, logic [31:0] wd, logic [3:0] be,
                               logic re, logic [4:0] ra, logic [4:0] ca, logic [31:0] ed,
                               logic [31:0] ep, logic es, logic [15:0] ec);
      vec_t v;
      v.wr_en = we; v.wr_add = wa; v.wr_data = wd; v.be = be;
      v.resv_en = re; v.resv_add = ra; v.chk_add = ca; v.exp_data = ed;
      v.exp_pend = ep; v.exp_stray = es; v.exp_cnt = ec;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [3:0] be, input logic re, input logic [4:0] ra);
      WrEn = we; WrAdd = wa; WrData = wd; WrByteEn = be; ResvEn = re; ResvAdd = ra;
   endtask

   initial begin
      vec_t e;
      // Expected state after each edge, starting from reset (all zero).
      vecs[0]  = mk(1, 5,  32'hDEADBEEF, 4'hF, 0, 0, 5,  32'hDEADBEEF, 32'h0,   1, 16'd1);
      vecs[1]  = mk(0, 5,  32'h0,        4'hF, 0, 0, 5,  32'hDEADBEEF, 32'h0,   0, 16'd1);
      vecs[2]  = mk(1, 7,  32'h11223344, 4'hF, 0, 0, 7,  32'h11223344, 32'h0,   1, 16'd2);
      vecs[3]  = mk(1, 7,  32'hAABBCCDD, 4'h5, 0, 0, 7,  32'h11BB33DD, 32'h0,   1, 16'd3);
      vecs[4]  = mk(0, 0,  32'h0,        4'h0, 1, 9, 9,  32'h0,        32'h200, 0, 16'd3);
      vecs[5]  = mk(0, 0,  32'h0,        4'h0, 0, 0, 9,  32'h0,        32'h200, 0, 16'd3);
      vecs[6]  = mk(1, 9,  32'h12345678, 4'hF, 0, 0, 9,  32'h12345678, 32'h0,   0, 16'd4);
      vecs[7]  = mk(0, 0,  32'h0,        4'h0, 1, 9, 9,  32'h12345678, 32'h200, 0, 16'd4);
      vecs[8]  = mk(1, 9,  32'hCAFEF00D, 4'hF, 1, 9, 9,  32'hCAFEF00D, 32'h200, 0, 16'd5);
      vecs[9]  = mk(1, 9,  32'h0,        4'h0, 0, 0, 9,  32'hCAFEF00D, 32'h200, 0, 16'd5);
      vecs[10] = mk(1, 9,  32'hFFFFFFFF, 4'h8, 1, 3, 9,  32'hFFFEF00D, 32'h8,   0, 16'd6);
      vecs[11] = mk(1, 3,  32'h00000005, 4'hF, 0, 0, 3,  32'h00000005, 32'h0,   0, 16'd7);
      vecs[12] = mk(1, 31, 32'hA5A5A5A5, 4'h3, 0, 0, 31, 32'h0000A5A5, 32'h0,   1, 16'd8);
`ifdef ZERO_REG_EN
      vecs[13] = mk(1, 0,  32'h00000001, 4'hF, 0, 0, 0,  32'h0,        32'h0,   0, 16'd9);
      vecs[14] = mk(0, 0,  32'h0,        4'h0, 1, 0, 0,  32'h0,        32'h0,   0, 16'd9);
      vecs[15] = mk(1, 0,  32'h00000002, 4'hF, 0, 0, 0,  32'h0,        32'h0,   0, 16'd10);
`else
      vecs[13] = mk(1, 0,  32'h00000001, 4'hF, 0, 0, 0,  32'h00000001, 32'h0,   1, 16'd9);
      vecs[14] = mk(0, 0,  32'h0,        4'h0, 1, 0, 0,  32'h00000001, 32'h1,   0, 16'd9);
      vecs[15] = mk(1, 0,  32'h00000002, 4'hF, 0, 0, 0,  32'h00000002, 32'h0,   0, 16'd10);
`endif

      // Reset at start: make a real falling edge on Reset_n.
      drive(0, 0, 0, 0, 0, 0);
      Reset_n = 1'b1;
      #1 Reset_n = 1'b0;
      #1;
      chk("reset_r0", r_out[0], 32'h0);
      chk("reset_r31", r_out[31], 32'h0);
      chk("reset_pending", Pending, 32'h0);
      chk("reset_stray", {31'h0, StrayWr}, 32'h0);
      chk("reset_count", {16'h0, WrCount}, 32'h0);
      #10 Reset_n = 1'b1;   // released at t=12, between edges

      // Table vectors through the scoreboard queue.
      for (int i = 0; i < NVEC; i++) begin
         drive(vecs[i].wr_en, vecs[i].wr_add, vecs[i].wr_data, vecs[i].be,
               vecs[i].resv_en, vecs[i].resv_add);
         sb_q.push_back(vecs[i]);
         step();
         e = sb_q.pop_front();
         chk($sformatf("vec%0d_data_r%0d", i, e.chk_add), r_out[e.chk_add], e.exp_data);
         chk($sformatf("vec%0d_pending", i), Pending, e.exp_pend);
         chk($sformatf("vec%0d_stray", i), {31'h0, StrayWr}, {31'h0, e.exp_stray});
         chk($sformatf("vec%0d_count", i), {16'h0, WrCount}, {16'h0, e.exp_cnt});
         $display("vec %0d: wr=%0d add=%0d data=%h be=%h resv=%0d/%0d -> r%0d=%h pend=%h stray=%0d cnt=%0d",
                  i, e.wr_en, e.wr_add, e.wr_data, e.be, e.resv_en, e.resv_add,
                  e.chk_add, r_out[e.chk_add], Pending, StrayWr, WrCount);
      end

      // Counter wrap: reserve r20, then bring the count to 16'hFFFF with writes to r1.
      drive(0, 0, 0, 0, 1, 20);
      step();
      drive(1, 1, 32'h0000_0001, 4'hF, 0, 0);
      for (int n = 0; n < 65535 - 10; n++) step();
      chk("count_ffff", {16'h0, WrCount}, 32'h0000FFFF);
      step();
      chk("count_wrap", {16'h0, WrCount}, 32'h0);
      chk("wrap_pending", Pending, 32'h0010_0000);
      $display("wrap: cnt=%0d pend=%h", WrCount, Pending);

      // WrEn with no byte enables is not committed.
      drive(1, 20, 32'hFFFFFFFF, 4'h0, 0, 0);
      step();
      chk("be0_count", {16'h0, WrCount}, 32'h0);
      chk("be0_pending", Pending, 32'h0010_0000);
      chk("be0_stray", {31'h0, StrayWr}, 32'h0);
      chk("be0_data", r_out[20], 32'h0);
      $display("be0 write: cnt=%0d pend=%h r20=%h", WrCount, Pending, r_out[20]);

      // Clear r20, set r3=5, then reserve r16..r31.
      drive(1, 20, 32'h0, 4'hF, 0, 0);
      step();
      drive(1, 3, 32'h5, 4'hF, 0, 0);
      step();
      for (int r = 16; r < 32; r++) begin
         drive(0, 0, 0, 0, 1, 5'(r));
         step();
      end
      drive(0, 0, 0, 0, 0, 0);
      chk("pre_rst_r3", r_out[3], 32'h5);
      chk("pre_rst_pending", Pending, 32'hFFFF0000);

      // Asynchronous reset between edges.
      #3 Reset_n = 1'b0;
      #1;
      chk("async_rst_r3", r_out[3], 32'h0);
      chk("async_rst_pending", Pending, 32'h0);
      chk("async_rst_count", {16'h0, WrCount}, 32'h0);
      chk("async_rst_r9", r_out[9], 32'h0);
      $display("async reset: r3=%h pend=%h cnt=%0d", r_out[3], Pending, WrCount);
      #2 Reset_n = 1'b1;

      // First edge after release operates normally.
      drive(1, 4, 32'h77, 4'hF, 0, 0);
      step();
      drive(0, 0, 0, 0, 0, 0);
      chk("post_rst_r4", r_out[4], 32'h77);
      chk("post_rst_count", {16'h0, WrCount}, 32'h1);
      chk("post_rst_stray", {31'h0, StrayWr}, 32'h1);
      $display("post reset write: r4=%h cnt=%0d stray=%0d", r_out[4], WrCount, StrayWr);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
